// File: rtl/stream_decryptor.sv
// Receive side of the LFSR XOR stream cipher: framed ciphertext in,
// framed plaintext out through a one-deep registered output stage.
module stream_decryptor #(
  parameter logic [7:0] SEED    = 8'hA3,
  parameter int         MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ct_valid,
  output logic        ct_ready,
  input  logic [7:0]  ct_data,
  input  logic        ct_sof,
  input  logic        ct_eof,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [7:0]  pt_data,
  output logic        pt_sof,
  output logic        pt_eof,
  output logic [7:0]  ks_out,
  output logic [7:0]  byte_cnt,
  output logic [15:0] frame_cnt,
  output logic        err_orphan,
  output logic        err_abort,
  output logic        err_len
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [7:0] MAXL = 8'(MAX_LEN);

  function automatic logic [7:0] step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  state_t     state;
  logic [7:0] lfsr;
  logic       accept;
  logic       in_frame;
  logic [7:0] key;
  logic [7:0] cnt_nx;
  logic       hit_max;
  logic       done;

  assign ct_ready = !reset & (!pt_valid | pt_ready);
  assign accept   = ct_valid & ct_ready;
  assign in_frame = ct_sof | (state == ACTIVE);
  assign key      = ct_sof ? SEED : lfsr;
  assign cnt_nx   = ct_sof ? 8'd1 : byte_cnt + 8'd1;
  assign hit_max  = (cnt_nx == MAXL);
  assign done     = ct_eof | hit_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      pt_valid   <= 1'b0;
      pt_data    <= 8'd0;
      pt_sof     <= 1'b0;
      pt_eof     <= 1'b0;
      ks_out     <= 8'd0;
      byte_cnt   <= 8'd0;
      frame_cnt  <= 16'd0;
      err_orphan <= 1'b0;
      err_abort  <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      if (pt_ready)
        pt_valid <= 1'b0;
      if (accept) begin
        if (in_frame) begin
          pt_valid <= 1'b1;
          pt_data  <= ct_data ^ key;
          ks_out   <= key;
          pt_sof   <= ct_sof;
          pt_eof   <= done;
          byte_cnt <= cnt_nx;
          if (ct_sof && state == ACTIVE)
            err_abort <= 1'b1;
          if (hit_max && !ct_eof)
            err_len <= 1'b1;
          // Closing a frame rearms the keystream for the next sof
          if (done) begin
            frame_cnt <= frame_cnt + 16'd1;
            lfsr      <= SEED;
            state     <= IDLE;
          end else begin
            lfsr  <= step(key);
            state <= ACTIVE;
          end
        end else begin
          err_orphan <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_decryptor.sv
// Scoreboard bench for stream_decryptor: expected plaintext is queued
// at ciphertext accept and compared when the output handshake fires.
module tb_stream_decryptor;

  localparam int MAXL = 4;

  logic        clk;
  logic        reset;
  logic        ct_valid;
  logic        ct_ready;
  logic [7:0]  ct_data;
  logic        ct_sof;
  logic        ct_eof;
  logic        pt_valid;
  logic        pt_ready;
  logic [7:0]  pt_data;
  logic        pt_sof;
  logic        pt_eof;
  logic [7:0]  ks_out;
  logic [7:0]  byte_cnt;
  logic [15:0] frame_cnt;
  logic        err_orphan;
  logic        err_abort;
  logic        err_len;

  stream_decryptor #(.SEED(8'hA3), .MAX_LEN(MAXL)) dut (
    .clk(clk), .reset(reset),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .ct_sof(ct_sof), .ct_eof(ct_eof),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .pt_sof(pt_sof), .pt_eof(pt_eof), .ks_out(ks_out),
    .byte_cnt(byte_cnt), .frame_cnt(frame_cnt),
    .err_orphan(err_orphan), .err_abort(err_abort), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] k;
    logic       s;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ks_tab [5];
  int         n_chk = 0;
  int         n_err = 0;
  logic       m_active = 1'b0;
  int         m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [7:0] d, input logic s, input logic e);
    exp_t x;
    if (!s && !m_active) return;
    m_cnt = s ? 1 : m_cnt + 1;
    x.d = d ^ ks_tab[m_cnt-1];
    x.k = ks_tab[m_cnt-1];
    x.s = s;
    x.e = e | (m_cnt == MAXL);
    sb.push_back(x);
    m_active = !x.e;
  endtask

  // Call at a falling edge; returns just after the accepting rising edge.
  task automatic send(input logic [7:0] d, input logic s, input logic e);
    logic acc;
    ct_valid = 1'b1;
    ct_data  = d;
    ct_sof   = s;
    ct_eof   = e;
    for (int i = 0; i < 50; i++) begin
      #1;
      acc = ct_ready;
      if (acc) model(d, s, e);
      @(posedge clk);
      if (acc) return;
      @(negedge clk);
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic tx(input logic [7:0] d, input logic s, input logic e);
    @(negedge clk);
    send(d, s, e);
  endtask

  task automatic drain();
    @(negedge clk);
    ct_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    #2;
    if (!reset && pt_valid && pt_ready) begin
      if (sb.size() == 0) begin
        check("extra_pt", 1, 0);
      end else begin
        x = sb.pop_front();
        check("pt_data", pt_data, x.d);
        check("ks_out", ks_out, x.k);
        check("pt_sof", pt_sof, x.s);
        check("pt_eof", pt_eof, x.e);
      end
    end
  end

  initial begin
    ks_tab[0] = 8'hA3; ks_tab[1] = 8'h46; ks_tab[2] = 8'h8C;
    ks_tab[3] = 8'h18; ks_tab[4] = 8'h30;
    reset = 1'b1; ct_valid = 1'b0; ct_data = 8'h00;
    ct_sof = 1'b0; ct_eof = 1'b0; pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_pt_valid", pt_valid, 0);
    check("rst_pt_data", pt_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_errs", {err_orphan, err_abort, err_len}, 0);
    check("rst_ct_ready", ct_ready, 1);

    // basic frame
    tx(8'hE7, 1, 0); tx(8'h2F, 0, 0); tx(8'hEB, 0, 1);
    drain();
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_byte_cnt", byte_cnt, 3);

    // stall on the second byte
    tx(8'hE7, 1, 0); tx(8'h2F, 0, 0);
    @(negedge clk);
    pt_ready = 1'b0;
    fork
      send(8'hEB, 0, 1);
      begin
        repeat (3) begin
          #1;
          check("stall_ct_ready", ct_ready, 0);
          check("stall_pt_data", pt_data, 8'h69);
          check("stall_ks", ks_out, 8'h46);
          @(negedge clk);
        end
        pt_ready = 1'b1;
      end
    join
    drain();
    check("f2_frame_cnt", frame_cnt, 2);

    // orphan then single-byte frame
    tx(8'h55, 0, 0);
    @(negedge clk);
    ct_valid = 1'b0;
    #1;
    check("orphan_pt_valid", pt_valid, 0);
    check("err_orphan", err_orphan, 1);
    tx(8'hE7, 1, 1);
    drain();
    check("f3_frame_cnt", frame_cnt, 3);

    // abort mid-frame
    tx(8'hE7, 1, 0); tx(8'h2F, 0, 0); tx(8'hE7, 1, 0);
    drain();
    check("err_abort", err_abort, 1);
    check("abort_frame_cnt", frame_cnt, 3);
    tx(8'h2F, 0, 1);
    drain();
    check("f4_frame_cnt", frame_cnt, 4);

    // length limit, fifth byte is an orphan
    tx(8'hE7, 1, 0); tx(8'h2F, 0, 0); tx(8'hEB, 0, 0);
    tx(8'h11, 0, 0); tx(8'h22, 0, 0);
    drain();
    check("err_len", err_len, 1);
    check("len_frame_cnt", frame_cnt, 5);
    check("len_byte_cnt", byte_cnt, 4);

    // reset with a pending output byte
    @(negedge clk);
    pt_ready = 1'b0;
    send(8'hE7, 1, 0);
    @(negedge clk);
    ct_valid = 1'b0;
    check("pre_rst_valid", pt_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", pt_valid, 0);
    check("mid_rst_data", {pt_data, ks_out}, 0);
    check("mid_rst_cnts", {frame_cnt, byte_cnt}, 0);
    check("mid_rst_errs", {err_orphan, err_abort, err_len}, 0);
    sb.delete();
    m_active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pt_ready = 1'b1;
    tx(8'hE7, 1, 0); tx(8'h2F, 0, 1);
    drain();
    check("post_rst_frame_cnt", frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
